// File: rtl/dct_sample_seq_if.sv
// Sample-sequencer bus: the control inputs and the position/strobe outputs.
// The master drives the controls; the slave (the sequencer) drives the strobes.
interface dct_sample_seq_if #(
  parameter int BLK_DIM = 8
);
  localparam int CW = $clog2(BLK_DIM*BLK_DIM);
  localparam int HW = $clog2(BLK_DIM);

  logic          ena;
  logic          clr;
  logic          din_valid;
  logic [CW-1:0] sample_cnt;
  logic [HW-1:0] row;
  logic [HW-1:0] col;
  logic [1:0]    ch;
  logic          sob;
  logic          eob;
  logic          done;
  logic [15:0]   blk_cnt;

  modport master (
    output ena, clr, din_valid,
    input  sample_cnt, row, col, ch, sob, eob, done, blk_cnt
  );
  modport slave (
    input  ena, clr, din_valid,
    output sample_cnt, row, col, ch, sob, eob, done, blk_cnt
  );
endinterface

// File: rtl/dct_sample_seq.sv
// Walks the sample positions of a BLK_DIM x BLK_DIM block and rotates across
// the interleaved channels. It flags the block edges and signals a delayed done.
module dct_sample_seq #(
  parameter int BLK_DIM  = 8,
  parameter int N_CH     = 3,
  parameter int DONE_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  dct_sample_seq_if.slave bus
);
  localparam int             CW      = $clog2(BLK_DIM*BLK_DIM);
  localparam int             HW      = $clog2(BLK_DIM);
  localparam logic [CW-1:0]  LAST    = CW'(BLK_DIM*BLK_DIM-1);
  localparam logic [1:0]     CH_LAST = 2'(N_CH-1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ch_q, ch_d;
  logic [15:0]   blk_q, blk_d;
  logic          sob_q, sob_d;
  logic          eob_q, eob_d;
  logic          accept, wrap;

  assign accept = bus.ena & bus.din_valid & ~bus.clr;
  assign wrap   = accept && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    ch_d  = ch_q;
    blk_d = blk_q;
    sob_d = sob_q;
    eob_d = eob_q;
    if (bus.ena) begin
      if (bus.clr) begin
        cnt_d = '0;
        ch_d  = '0;
        blk_d = '0;
        sob_d = 1'b0;
        eob_d = 1'b0;
      end else begin
        sob_d = accept && (cnt_q == '0);
        eob_d = wrap;
        // BLK_DIM is a power of two, so the counter wraps on its own.
        if (accept) cnt_d = cnt_q + CW'(1);
        if (wrap) begin
          ch_d  = (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
          blk_d = blk_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ch_q  <= '0;
      blk_q <= '0;
      sob_q <= 1'b0;
      eob_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
      blk_q <= blk_d;
      sob_q <= sob_d;
      eob_q <= eob_d;
    end
  end

  // Delays done behind eob; it advances only on enabled cycles, and clr drops in-flight tokens.
  generate
    if (DONE_LAT == 0) begin : g_nodly
      assign bus.done = eob_q;
    end else begin : g_dly
      logic [DONE_LAT-1:0] done_pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          done_pipe_q <= '0;
        end else if (bus.ena) begin
          if (bus.clr) begin
            done_pipe_q <= '0;
          end else begin
            done_pipe_q[0] <= eob_q;
            for (int i = 1; i < DONE_LAT; i++) done_pipe_q[i] <= done_pipe_q[i-1];
          end
        end
      end
      assign bus.done = done_pipe_q[DONE_LAT-1];
    end
  endgenerate

  assign bus.sample_cnt = cnt_q;
  assign bus.row        = cnt_q[CW-1 -: HW];
  assign bus.col        = cnt_q[HW-1:0];
  assign bus.ch         = ch_q;
  assign bus.sob        = sob_q;
  assign bus.eob        = eob_q;
  assign bus.blk_cnt    = blk_q;
endmodule

// File: tb/tb_dct_sample_seq.sv
// Directed bench for dct_sample_seq. The default instance is u0; u1 (4x4, one
// channel, no done delay) shares u0's control inputs.
module tb_dct_sample_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;
  int   neob, ndone, nbad;

  always #5 clk = ~clk;

  dct_sample_seq_if #(.BLK_DIM(8)) bus0 ();
  dct_sample_seq_if #(.BLK_DIM(4)) bus1 ();

  assign bus1.ena       = bus0.ena;
  assign bus1.clr       = bus0.clr;
  assign bus1.din_valid = bus0.din_valid;

  dct_sample_seq #(.BLK_DIM(8), .N_CH(3), .DONE_LAT(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  dct_sample_seq #(.BLK_DIM(4), .N_CH(1), .DONE_LAT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cnt"},  32'(bus0.sample_cnt), 0);
    chk({tag, ".ch"},   32'(bus0.ch), 0);
    chk({tag, ".blk"},  32'(bus0.blk_cnt), 0);
    chk({tag, ".sob"},  32'(bus0.sob), 0);
    chk({tag, ".eob"},  32'(bus0.eob), 0);
    chk({tag, ".done"}, 32'(bus0.done), 0);
  endtask

  initial begin
    bus0.ena = 1'b1; bus0.clr = 1'b0; bus0.din_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    #11 rst_n = 1'b1;
    #4;

    // One block of 64 consecutive accepts. u1 sees four 16-sample blocks.
    bus0.din_valid = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      chk($sformatf("blk1.sob[%0d]", k), 32'(bus0.sob), 32'(k == 1));
      chk($sformatf("blk1.eob[%0d]", k), 32'(bus0.eob), 32'(k == 64));
      chk($sformatf("u1.eob[%0d]", k), 32'(bus1.eob), 32'(k % 16 == 0));
      chk($sformatf("u1.done[%0d]", k), 32'(bus1.done), 32'(bus1.eob));
      chk($sformatf("u1.ch[%0d]", k), 32'(bus1.ch), 0);
    end
    chk("u1.blk", 32'(bus1.blk_cnt), 4);
    bus0.din_valid = 1'b0;
    cyc();
    chk("blk1.done65", 32'(bus0.done), 0);
    chk("blk1.eob65", 32'(bus0.eob), 0);
    cyc();
    chk("blk1.done66", 32'(bus0.done), 1);
    cyc();
    chk("blk1.done67", 32'(bus0.done), 0);
    chk("blk1.ch", 32'(bus0.ch), 1);
    chk("blk1.blk", 32'(bus0.blk_cnt), 1);
    chk("blk1.cnt", 32'(bus0.sample_cnt), 0);

    // Three blocks from a fresh reset: channel rotation and pulse counts.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    neob = 0; ndone = 0;
    for (int k = 1; k <= 195; k++) begin
      bus0.din_valid = (k <= 192);
      cyc();
      neob  += int'(bus0.eob);
      ndone += int'(bus0.done);
      if (k == 64)  chk("b3.ch64", 32'(bus0.ch), 1);
      if (k == 128) chk("b3.ch128", 32'(bus0.ch), 2);
      if (k == 192) chk("b3.ch192", 32'(bus0.ch), 0);
    end
    chk("b3.neob", 32'(neob), 3);
    chk("b3.ndone", 32'(ndone), 3);
    chk("b3.blk", 32'(bus0.blk_cnt), 3);

    // Partial block, then clr (also asserted with din_valid to test priority).
    bus0.din_valid = 1'b1;
    repeat (20) cyc();
    chk("part.cnt", 32'(bus0.sample_cnt), 20);
    chk("part.row", 32'(bus0.row), 2);
    chk("part.col", 32'(bus0.col), 4);
    bus0.clr = 1'b1;
    cyc();
    chk("clr.cnt", 32'(bus0.sample_cnt), 0);
    chk("clr.ch", 32'(bus0.ch), 0);
    chk("clr.blk", 32'(bus0.blk_cnt), 0);
    chk("clr.sob", 32'(bus0.sob), 0);
    bus0.clr = 1'b0; bus0.din_valid = 1'b0;
    nbad = 0;
    repeat (70) begin
      cyc();
      nbad += int'(bus0.eob | bus0.done);
    end
    chk("clr.noeob", 32'(nbad), 0);

    // Enable hold with eob high, then with a token inside the done pipeline.
    bus0.din_valid = 1'b1;
    repeat (64) cyc();
    chk("hold.eob0", 32'(bus0.eob), 1);
    bus0.ena = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("hold.eob[%0d]", k), 32'(bus0.eob), 1);
      chk($sformatf("hold.done[%0d]", k), 32'(bus0.done), 0);
    end
    chk("hold.cnt", 32'(bus0.sample_cnt), 0);
    bus0.ena = 1'b1; bus0.din_valid = 1'b0;
    cyc();
    chk("hold.eobfall", 32'(bus0.eob), 0);
    chk("hold.done1", 32'(bus0.done), 0);
    bus0.ena = 1'b0;
    repeat (3) begin
      cyc();
      chk("hold.donefrz", 32'(bus0.done), 0);
    end
    bus0.ena = 1'b1;
    cyc();
    chk("hold.done2", 32'(bus0.done), 1);
    cyc();
    chk("hold.done3", 32'(bus0.done), 0);

    // Asynchronous reset one cycle after eob, while done is still in flight.
    bus0.din_valid = 1'b1;
    repeat (64) cyc();
    bus0.din_valid = 1'b0;
    cyc();
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    #2 rst_n = 1'b1;
    nbad = 0;
    repeat (5) begin
      cyc();
      nbad += int'(bus0.done);
    end
    chk("arst.nodone", 32'(nbad), 0);
    bus0.din_valid = 1'b1;
    cyc();
    chk("arst.sob", 32'(bus0.sob), 1);
    chk("arst.cnt", 32'(bus0.sample_cnt), 1);
    chk("arst.ch", 32'(bus0.ch), 0);
    bus0.din_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/dct_sample_seq.md
DCT_SAMPLE_SEQ -- requirements
Module: dct_sample_seq

Interface
- REQ-001 The block SHALL have parameter BLK_DIM, default 8, giving the block edge in samples (power of two, 2..16).
- REQ-002 The block SHALL have parameter N_CH, default 3, giving the number of interleaved colour channels (1..4).
- REQ-003 The block SHALL have parameter DONE_LAT, default 2, giving the extra cycles from eob to done (0..8).
- REQ-004 The block SHALL use CW = log2(BLK_DIM*BLK_DIM) and HW = log2(BLK_DIM) as widths.
- REQ-005 Port clk, input, 1: the single clock; all state on rising edge.
- REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
- REQ-007 Port ena, input, 1: global clock enable; when low, all state holds.
- REQ-008 Port clr, input, 1: synchronous clear, qualified by ena.
- REQ-009 Port din_valid, input, 1: one sample presented this cycle.
- REQ-010 Port sample_cnt, output, CW: index of the next sample within the block.
- REQ-011 Port row and port col, output, HW each: sample_cnt split as {row, col}.
- REQ-012 Port ch, output, 2: channel of the current block.
- REQ-013 Port sob, output, 1: registered start-of-block pulse.
- REQ-014 Port eob, output, 1: registered end-of-block pulse.
- REQ-015 Port done, output, 1: eob delayed DONE_LAT enabled cycles.
- REQ-016 Port blk_cnt, output, 16: count of completed blocks.

Function
- REQ-017 A sample SHALL be accepted when ena=1, din_valid=1 and clr=0.
- REQ-018 On accept, sample_cnt SHALL increment by 1. From BLK_DIM*BLK_DIM-1 it SHALL wrap to 0.
- REQ-019 row and col SHALL be combinational slices of sample_cnt: row = MSBs, col = LSBs.
- REQ-020 sob SHALL be 1 for exactly one cycle following an accept with sample_cnt=0, and 0 otherwise.
- REQ-021 eob SHALL be 1 for exactly one cycle following an accept with sample_cnt=BLK_DIM*BLK_DIM-1, and 0 otherwise.
- REQ-022 On the wrap accept, ch SHALL advance by 1. From N_CH-1 it SHALL wrap to 0.
- REQ-023 On the wrap accept, blk_cnt SHALL increment modulo 2^16.
- REQ-024 done SHALL come from a DONE_LAT-stage shift register fed by eob.
  - The shift register advances only when ena=1.
  - When DONE_LAT=0, done SHALL equal eob.
- REQ-025 If BLK_DIM=2, one accept MAY set sob and eob in different cycles only. The sample_cnt=0 and last-index conditions SHALL never coincide.
- REQ-026 When ena=0, sob and eob SHALL hold their values. The pulse-width rule in REQ-020/021 counts enabled cycles only.
- REQ-027 clr=1 with ena=1 SHALL have priority over din_valid. It SHALL zero:
  - sample_cnt, ch and blk_cnt;
  - sob and eob;
  - the done pipeline.
- REQ-028 A clr arriving mid-block SHALL discard the partial block: no eob, no done, no blk_cnt increment.
- REQ-029 din_valid=0 SHALL leave counters unchanged and drive sob=eob=0 on the next enabled cycle.
- REQ-030 ch SHALL be zero-extended to 2 bits. Values of N_CH or above SHALL never appear.

Reset
- REQ-031 rst_n=0 SHALL immediately and asynchronously set all of the following to 0, with no clock required:
  - sample_cnt, ch and blk_cnt;
  - sob, eob and done;
  - every done pipeline stage.
- REQ-032 After rst_n deasserts, the first accept SHALL be treated as sample 0 of channel 0.
- REQ-033 Reset asserted mid-block or mid-pipeline SHALL discard all in-flight state. No pending done SHALL emerge after release.

Verification
- REQ-034 Defaults, 64 consecutive accepts from reset:
  - sob=1 in cycle 1 only;
  - eob=1 in cycle 64 only;
  - done=1 in cycle 66;
  - ch=1 and blk_cnt=1 after.
- REQ-035 Defaults, 192 accepts: ch sequence 0→1→2→0, blk_cnt=3, three eob and three done pulses.
- REQ-036 Accept 20 samples (row=2, col=4), then pulse clr: sample_cnt=0 and ch=0. No eob or done pulse ever follows.
- REQ-037 ena=0 for 5 cycles while eob=1 and the done pipeline holds a token:
  - eob stays 1 through the hold;
  - done appears exactly DONE_LAT enabled cycles later.
- REQ-038 Assert rst_n=0 asynchronously between clock edges, one cycle after eob:
  - all outputs read 0 immediately;
  - no done pulse follows release.
- REQ-039 BLK_DIM=4, N_CH=1, DONE_LAT=0, 65536*16 accepts:
  - blk_cnt wraps 0xFFFF→0x0000;
  - ch stays 0;
  - done coincides with eob.
